// File: rtl/cisc_mem_pkg.sv
// -----------------------------------------------------------------------------
// cisc_mem_pkg
// Shared constants for the CISC memory interface:
//   - FSM state encoding (IDLE / ACCESS / DONE)
//   - default address/data widths and timeout length
//   - read data returned to the CPU when an access is aborted by timeout
// Consumed by cisc_mem_if and cisc_mem_timer via import cisc_mem_pkg::*.
// -----------------------------------------------------------------------------
package cisc_mem_pkg;

    // Default geometry and timeout length
    localparam int unsigned DEF_ADDR_W  = 16;
    localparam int unsigned DEF_DATA_W  = 16;
    localparam int unsigned DEF_TIMEOUT = 15;

    // Width of the timeout counter; TIMEOUT is limited to 1..255
    localparam int unsigned TIMER_W     = 8;

    // FSM state encoding, kept as plain constants for legacy tools
    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_ACCESS = 2'b01;
    localparam logic [1:0] ST_DONE   = 2'b10;

    // Aborted reads return all ones; the bit form lets any DATA_W replicate it
    localparam logic                  ERR_RDATA_BIT = 1'b1;
    localparam logic [DEF_DATA_W-1:0] ERR_RDATA     = {DEF_DATA_W{ERR_RDATA_BIT}};

endpackage : cisc_mem_pkg

// File: rtl/cisc_mem_timer.sv
// -----------------------------------------------------------------------------
// cisc_mem_timer
// Counts ACCESS cycles for the CISC memory interface and flags the cycle in
// which the running count (starting at 1 in the first ACCESS cycle) reaches
// TIMEOUT.
// Ports:
//   clk     in   rising-edge clock
//   rst     in   asynchronous active-low reset
//   clr     in   clear the count (asserted on entry to ACCESS)
//   en      in   count this cycle (asserted while in ACCESS)
//   expired out  combinational: en=1 and this cycle is the TIMEOUT-th one
// Parameter:
//   TIMEOUT      cycles allowed without completion, 1..255
// -----------------------------------------------------------------------------
module cisc_mem_timer
    import cisc_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    // cnt_q holds the number of ACCESS cycles already completed, so the
    // current cycle number is cnt_q + 1.
    logic [TIMER_W-1:0] cnt_q;
    logic [TIMER_W-1:0] cnt_d;
    logic [TIMER_W:0]   cur_cycle_s;

    // Next count: clear has priority over counting
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {TIMER_W{1'b0}};
        end else if (en) begin
            cnt_d = cnt_q + {{(TIMER_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Expiry flag for the current ACCESS cycle
    always_comb begin
        cur_cycle_s = {1'b0, cnt_q} + {{TIMER_W{1'b0}}, 1'b1};
        if (en && (cur_cycle_s == (TIMER_W+1)'(TIMEOUT))) begin
            expired = 1'b1;
        end else begin
            expired = 1'b0;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= {TIMER_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : cisc_mem_timer

// File: rtl/cisc_mem_if.sv
// -----------------------------------------------------------------------------
// cisc_mem_if
// Single-outstanding CPU-to-memory access sequencer. A CPU request is latched
// in IDLE, presented to memory (mem_en) during ACCESS until mem_ack, and
// completed with a one-cycle cpu_ready pulse in DONE.
//
// Optional feature (macro CISC_MEM_TIMEOUT_EN): an ACCESS that sees no mem_ack
// for TIMEOUT cycles is aborted; cpu_ready then comes with cpu_err=1 and
// cpu_rdata=all ones. Without the macro ACCESS waits forever and cpu_err=0.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   cpu_req, cpu_we               request level, 1=write
//   cpu_addr, cpu_wdata           request address / write data
//   cpu_rdata                     read data returned to the CPU
//   cpu_ready                     one-cycle completion pulse
//   cpu_busy                      high in ACCESS and DONE
//   cpu_err                       timeout abort, valid with cpu_ready
//   mem_en, mem_we                memory strobe / write enable (ACCESS only)
//   mem_addr, mem_wdata           latched address / write data
//   mem_rdata, mem_ack            memory read data / completion
// Parameters: ADDR_W, DATA_W, TIMEOUT (1..255)
// -----------------------------------------------------------------------------
module cisc_mem_if
    import cisc_mem_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              cpu_busy,
    output logic              cpu_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    // Reject out-of-range TIMEOUT at elaboration
    if ((TIMEOUT < 1) || (TIMEOUT > 255)) begin : g_bad_timeout
        $error("cisc_mem_if: TIMEOUT must be in 1..255");
    end

    logic [1:0]        state_q,     state_d;
    logic              mem_en_q,    mem_en_d;
    logic              mem_we_q,    mem_we_d;
    logic              cpu_ready_q, cpu_ready_d;
    logic              cpu_busy_q,  cpu_busy_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;

`ifdef CISC_MEM_TIMEOUT_EN
    logic timer_clr_s;
    logic timer_en_s;
    logic timeout_s;
    logic cpu_err_q, cpu_err_d;

    // Counter restarts on every accepted request and runs only in ACCESS
    assign timer_clr_s = (state_q == ST_IDLE) && cpu_req;
    assign timer_en_s  = (state_q == ST_ACCESS);

    cisc_mem_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (timer_clr_s),
        .en      (timer_en_s),
        .expired (timeout_s)
    );

    // Error flag: only a timeout without a same-cycle ack is an error
    always_comb begin
        if ((state_q == ST_ACCESS) && !mem_ack && timeout_s) begin
            cpu_err_d = 1'b1;
        end else begin
            cpu_err_d = 1'b0;
        end
    end

    // Error flag register, lives only in DONE alongside cpu_ready
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_err_q <= 1'b0;
        end else begin
            cpu_err_q <= cpu_err_d;
        end
    end

    assign cpu_err = cpu_err_q;
`else
    assign cpu_err = 1'b0;
`endif

    // Next-state and next-output logic; every output is the registered image
    // of the state being entered, so outputs never glitch with inputs.
    always_comb begin
        state_d     = state_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        cpu_ready_d = 1'b0;
        cpu_busy_d  = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_rdata_d = cpu_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    state_d     = ST_ACCESS;
                    mem_addr_d  = cpu_addr;
                    mem_wdata_d = cpu_wdata;
                    mem_we_d    = cpu_we;
                    mem_en_d    = 1'b1;
                    cpu_busy_d  = 1'b1;
                end else begin
                    state_d     = ST_IDLE;
                end
            end

            ST_ACCESS: begin
                if (mem_ack) begin
                    state_d     = ST_DONE;
                    cpu_ready_d = 1'b1;
                    cpu_busy_d  = 1'b1;
                    if (!mem_we_q) begin
                        cpu_rdata_d = mem_rdata;
                    end else begin
                        cpu_rdata_d = cpu_rdata_q;
                    end
                end
`ifdef CISC_MEM_TIMEOUT_EN
                else if (timeout_s) begin
                    state_d     = ST_DONE;
                    cpu_ready_d = 1'b1;
                    cpu_busy_d  = 1'b1;
                    cpu_rdata_d = {DATA_W{ERR_RDATA_BIT}};
                end
`endif
                else begin
                    // Hold the request stable until memory responds
                    state_d     = ST_ACCESS;
                    mem_en_d    = 1'b1;
                    mem_we_d    = mem_we_q;
                    cpu_busy_d  = 1'b1;
                end
            end

            ST_DONE: begin
                // Always pass through IDLE so a held cpu_req is resampled there
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            cpu_ready_q <= 1'b0;
            cpu_busy_q  <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {DATA_W{1'b0}};
            cpu_rdata_q <= {DATA_W{1'b0}};
        end else begin
            state_q     <= state_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            cpu_ready_q <= cpu_ready_d;
            cpu_busy_q  <= cpu_busy_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ready = cpu_ready_q;
    assign cpu_busy  = cpu_busy_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule : cisc_mem_if

// File: doc/cisc_mem_if.md
CISC_MEM_IF -- requirements
Module: cisc_mem_if

Interface
REQ-001 The parameters SHALL be:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- TIMEOUT, 15, maximum ACCESS cycles without mem_ack, range 1..255.

REQ-002 The design SHALL use one clock; reset is asynchronous and active-low.

REQ-003 The ports SHALL be:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU access request (level).
- cpu_we  in  1  1=write, 0=read.
- cpu_addr  in  ADDR_W  CPU address (eab).
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  read data to CPU (edb).
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_busy  out  1  transaction in flight.
- cpu_err  out  1  transaction aborted by timeout (qualified by cpu_ready).
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- mem_ack  in  1  memory completion, valid only while mem_en=1.

Function
REQ-004 The FSM SHALL have three states, IDLE, ACCESS and DONE, with these transitions:
- IDLE->ACCESS when cpu_req=1 at a clock edge.
- ACCESS->DONE on mem_ack=1 or on timeout.
- DONE->IDLE unconditionally.

REQ-005 In IDLE with cpu_req=1, the block SHALL register cpu_addr, cpu_we and cpu_wdata into mem_addr, mem_we and mem_wdata at that edge.

REQ-006 In ACCESS, mem_en SHALL be 1, and mem_addr, mem_we and mem_wdata SHALL stay stable until the state is left.

REQ-007 In ACCESS with mem_ack=1 and mem_we=0, the block SHALL register mem_rdata into cpu_rdata at that edge.

REQ-008 For a write, cpu_rdata SHALL keep its previous value.

REQ-009 cpu_ready SHALL be 1 only in DONE, which lasts exactly one cycle. Minimum latency is 2 cycles from the cpu_req sample edge to the cpu_ready pulse (mem_ack in the first ACCESS cycle).

REQ-010 cpu_busy SHALL be 1 in ACCESS and DONE, and 0 in IDLE.

REQ-011 cpu_req SHALL be ignored in ACCESS and DONE; only one transaction is in flight at a time.

REQ-012 A cpu_req held high through DONE SHALL start a new transaction from the IDLE cycle that follows. There is no back-to-back DONE->ACCESS transition.

REQ-013 mem_ack SHALL be ignored in IDLE and DONE.

REQ-014 mem_en and mem_we SHALL be 0 in IDLE and DONE.

REQ-015 cpu_err SHALL be 0 in every cycle where cpu_ready=0.

Reset
REQ-016 rst=0 SHALL immediately force the following, including mid-transaction:
- state=IDLE;
- mem_en, mem_we, cpu_ready, cpu_busy, cpu_err = 0;
- mem_addr, mem_wdata, cpu_rdata = 0;
- timeout count = 0.

REQ-017 A transaction interrupted by reset SHALL be lost, with no cpu_ready pulse.

REQ-018 The first cpu_req SHALL be sampled at the first rising edge after rst deasserts.

Configuration
REQ-019 The macro CISC_MEM_TIMEOUT_EN SHALL compile the timeout feature in or out.

REQ-020 With CISC_MEM_TIMEOUT_EN defined, the timeout SHALL behave as follows:
- ACCESS cycles are counted from 1.
- If the count reaches TIMEOUT with mem_ack=0, the FSM goes to DONE with cpu_err=1 and cpu_rdata=all ones.
- If mem_ack=1 in the same cycle the count reaches TIMEOUT, ack wins and cpu_err=0.
- The count clears on entry to ACCESS.

REQ-021 Without CISC_MEM_TIMEOUT_EN, ACCESS SHALL wait indefinitely for mem_ack, cpu_err SHALL be tied to 0, and no counter logic SHALL exist.

Structure
REQ-022 The shared package cisc_mem_pkg SHALL hold the state encoding (IDLE=2'b00, ACCESS=2'b01, DONE=2'b10), the default ADDR_W, DATA_W and TIMEOUT constants, and the error read-data constant.

REQ-023 The timeout counter SHALL be one sub-module, cisc_mem_timer, with inputs clr and en, output expired, and parameter TIMEOUT. It SHALL be instantiated only under CISC_MEM_TIMEOUT_EN.

Verification
REQ-024 The bench SHALL cover at least these scenarios:
- Read, ack in the first ACCESS cycle: cpu_req=1, cpu_addr=16'h0040; memory returns 16'hBEEF with mem_ack on the cycle after the request edge -> cpu_ready pulse 2 cycles after the request edge, cpu_rdata=16'hBEEF, cpu_err=0.
- Write with 3 wait cycles: cpu_we=1, cpu_addr=16'h0012, cpu_wdata=16'h1234, mem_ack in the 4th ACCESS cycle -> mem_addr, mem_wdata and mem_we stable for 4 cycles; cpu_rdata unchanged; one cpu_ready pulse.
- cpu_req held high continuously, acks immediate -> transactions complete every 3 cycles (IDLE, ACCESS, DONE); requests during ACCESS/DONE are ignored.
- Timeout (macro on, TIMEOUT=15), mem_ack never asserted -> cpu_ready with cpu_err=1 and cpu_rdata=16'hFFFF after 15 ACCESS cycles. Variant: ack on the 15th cycle -> cpu_err=0.
- rst=0 in the 2nd ACCESS cycle -> mem_en drops without waiting for a clock edge; no cpu_ready; the next request after reset completes normally.
- Spurious mem_ack in IDLE with 16'hDEAD on mem_rdata -> cpu_rdata and all outputs unchanged.
